// File: rtl/amy_uart_tx_pkg.sv
// Register map, STATUS/CTRL bit layout and TX FSM encoding shared by the
// UART transmitter RTL, firmware headers and the bench.
package amy_uart_tx_pkg;

  localparam logic [3:0] REG_DATA    = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_BAUDDIV = 4'h8;
  localparam logic [3:0] REG_CTRL    = 4'hC;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_COUNT   = 8;
  localparam int STAT_COUNT_W = 5;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [STAT_COUNT_W-1:0] count);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    w[STAT_COUNT +: STAT_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/amy_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; read data is the head entry (show-ahead).
// A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
module amy_uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   wdata,
  output logic [7:0]                   rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/amy_uart_tx.sv
// AHB-Lite UART transmitter: zero-wait register slave feeding a byte FIFO that
// an 8N1 serialiser drains onto txd.
module amy_uart_tx
  import amy_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [3:0]  haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic        hready_in,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic        txd,
  output logic        tx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]    addr_p1;
  logic          write_p1;
  logic          vld_p1;
  logic          capture;
  logic          wr_active;
  logic          push;
  logic          pop;
  logic          busy;
  logic          bit_end;
  logic [15:0]   bauddiv;
  logic          tx_en;
  logic          irq_en;
  logic          overflow;
  tx_state_e     state;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_byte;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic [7:0]    fifo_rdata;
  logic [31:0]   status_word;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign hreadyout   = 1'b1;
  assign hresp       = 1'b0;
  assign unused_bits = ^{htrans[0], hwdata[31:16]};

  assign capture   = hsel & htrans[1] & hready_in;
  assign wr_active = vld_p1 & write_p1;
  assign push      = wr_active && (addr_p1 == REG_DATA);
  assign busy      = (state != TX_IDLE);
  assign pop       = (state == TX_IDLE) & tx_en & ~fifo_empty;
  assign bit_end   = (baud_cnt == 16'd0);

  assign status_word = pack_status(fifo_full, fifo_empty, busy, overflow,
                                   STAT_COUNT_W'(fifo_count));

  always_comb begin
    rd_word = '0;
    case (haddr)
      REG_STATUS:  rd_word = status_word;
      REG_BAUDDIV: rd_word = {16'h0, bauddiv};
      REG_CTRL:    rd_word = {30'h0, irq_en, tx_en};
      default:     rd_word = '0;
    endcase
  end

  // Address phase -> data phase: register offset, direction and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      addr_p1  <= '0;
      hrdata   <= '0;
    end else begin
      vld_p1 <= capture;
      if (capture) begin
        addr_p1  <= haddr;
        write_p1 <= hwrite;
        if (!hwrite) hrdata <= rd_word;
      end
    end
  end

  // Data phase: register writes and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bauddiv  <= BAUD_DIV_RST;
      tx_en    <= 1'b1;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_active && addr_p1 == REG_BAUDDIV) bauddiv <= hwdata[15:0];
      if (wr_active && addr_p1 == REG_CTRL) begin
        tx_en  <= hwdata[CTRL_TX_EN];
        irq_en <= hwdata[CTRL_IRQ_EN];
      end
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
      else if (wr_active && addr_p1 == REG_STATUS && hwdata[STAT_OVF])
        overflow <= 1'b0;
    end
  end

  amy_uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (hwdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (pop) tx_byte <= fifo_rdata;
  end

  // Serialiser: baud counter reloads from BAUDDIV at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_irq   <= 1'b0;
    end else begin
      tx_irq <= irq_en & fifo_empty & ~busy;
      case (state)
        TX_IDLE: begin
          if (pop) begin
            state    <= TX_START;
            txd      <= 1'b0;
            baud_cnt <= bauddiv;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state    <= TX_DATA;
            txd      <= tx_byte[0];
            bit_idx  <= '0;
            baud_cnt <= bauddiv;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= bauddiv;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_end) state    <= TX_IDLE;
          else         baud_cnt <= baud_cnt - 16'd1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amy_uart_tx.sv
// Bench for amy_uart_tx: directed bus sequences with random payloads, txd/tx_irq
// history checked against an arithmetic model of 8N1 frames and FIFO occupancy.
module tb_amy_uart_tx;
  import amy_uart_tx_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXC  = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hready_in;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        txd;
  logic        tx_irq;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  logic txd_hist [MAXC];
  logic irq_hist [MAXC];

  amy_uart_tx #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(16'd433)) dut (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hready_in (hready_in),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .txd       (txd),
    .tx_irq    (tx_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      txd_hist[cyc] <= txd;
      irq_hist[cyc] <= tx_irq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
    @(negedge clk);
    d = hrdata;
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_status(input int n, input bit ovf, input bit busy);
    int v;
    v = n * 256 + (ovf ? 8 : 0) + (busy ? 4 : 0) + ((n == 0) ? 2 : 0) + ((n == DEPTH) ? 1 : 0);
    return 32'(v);
  endfunction

  // Bits 0..chg-1 last p0 clocks, later bits p1 clocks; bit 0 start, 1..8 data LSB first, 9 stop.
  function automatic int frame_errs(input int s, input logic [7:0] d, input int p0,
                                    input int chg, input int p1);
    int pos;
    int errs;
    int per;
    logic v;
    pos = s;
    errs = 0;
    for (int j = 0; j < 10; j++) begin
      per = (j < chg) ? p0 : p1;
      v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
      for (int k = 0; k < per; k++) begin
        if (pos >= MAXC || txd_hist[pos] !== v) errs++;
        pos++;
      end
    end
    return errs;
  endfunction

  function automatic int first_fall(input int from);
    for (int c = from; c < from + 64 && c < MAXC; c++)
      if (txd_hist[c] === 1'b0) return c;
    return -1;
  endfunction

  initial begin
    logic [31:0] r;
    logic [7:0]  d;
    logic [7:0]  nb;
    logic [7:0]  q[$];
    bit          ovf;
    int          e, s, w, chg, len, b, rise, cnt;

    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hready_in = 1'b1; hwdata = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_hrdata", hrdata, 0);
    check("rst_irq", 32'(tx_irq), 0);
    check("hreadyout", 32'(hreadyout), 1);
    check("hresp", 32'(hresp), 0);
    rst = 1'b0;
    @(negedge clk);
    rd(REG_STATUS, r);  check("status_rst", r, exp_status(0, 0, 0));
    rd(REG_BAUDDIV, r); check("baud_rst", r, 433);
    rd(REG_CTRL, r);    check("ctrl_rst", r, 1);
    rd(REG_DATA, r);    check("data_read", r, 0);

    // Basic frame 0x55 at BAUDDIV=3.
    wr(REG_BAUDDIV, 32'd3);
    wr(REG_DATA, 32'h55);
    e = cyc; s = e + 1;
    rd(REG_STATUS, r); check("status_queued", r, exp_status(1, 0, 0));
    rd(REG_STATUS, r); check("status_busy", r, exp_status(0, 0, 1));
    wait_until(s + 39);
    rd(REG_STATUS, r); check("busy_last_clk", r, exp_status(0, 0, 1));
    rd(REG_STATUS, r); check("busy_cleared", r, exp_status(0, 0, 0));
    repeat (2) @(negedge clk);
    check("fall_pos", first_fall(e), s);
    check("frame_55", frame_errs(s, 8'h55, 4, 10, 4), 0);

    // Random bytes at random small divisors.
    for (int i = 0; i < 2; i++) begin
      b = int'($urandom_range(1, 4));
      d = 8'($urandom);
      wr(REG_BAUDDIV, 32'(b));
      wr(REG_DATA, {24'h0, d});
      e = cyc; s = e + 1; len = 10 * (b + 1);
      wait_until(s + len + 2);
      check($sformatf("rand_fall%0d", i), first_fall(e), s);
      check($sformatf("rand_frame%0d", i), frame_errs(s, d, b + 1, 10, b + 1), 0);
      check($sformatf("rand_idle%0d", i), 32'(txd_hist[s + len]), 1);
    end

    // Burst with tx disabled, overflow, then drain.
    wr(REG_BAUDDIV, 32'd3);
    wr(REG_CTRL, 32'd0);
    q.delete(); ovf = 0;
    for (int i = 0; i < 10; i++) begin
      wr(REG_DATA, 32'h30 + i);
      if (q.size() < DEPTH) q.push_back(8'(8'h30 + i));
      else ovf = 1;
    end
    rd(REG_STATUS, r); check("burst_status", r, exp_status(q.size(), ovf, 0));
    wr(REG_CTRL, 32'd1);
    s = cyc + 1;
    wait_until(s + q.size() * 41 + 2);
    for (int j = 0; j < q.size(); j++)
      check($sformatf("burst_frame%0d", j), frame_errs(s + j * 41, q[j], 4, 10, 4), 0);
    rd(REG_STATUS, r); check("drained_ovf", r, exp_status(0, ovf, 0));
    wr(REG_STATUS, 32'h8);
    rd(REG_STATUS, r); check("ovf_cleared", r, exp_status(0, 0, 0));

    // Push coinciding with the IDLE pop on a full FIFO.
    wr(REG_CTRL, 32'd0);
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      wr(REG_DATA, {24'h0, d});
      q.push_back(d);
    end
    rd(REG_STATUS, r); check("fill_status", r, exp_status(DEPTH, 0, 0));
    nb = 8'($urandom);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = REG_CTRL;
    @(negedge clk);
    hwdata = 32'd1; haddr = REG_DATA;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = {24'h0, nb};
    @(negedge clk);
    s = cyc;
    q.push_back(nb);
    rd(REG_STATUS, r); check("pushpop_status", r, exp_status(q.size() - 1, 0, 1));
    wait_until(s + q.size() * 41 + 2);
    for (int j = 0; j < q.size(); j++)
      check($sformatf("pushpop_frame%0d", j), frame_errs(s + j * 41, q[j], 4, 10, 4), 0);
    rd(REG_STATUS, r); check("pushpop_done", r, exp_status(0, 0, 0));

    // Interrupt level and mid-frame baud change.
    wr(REG_CTRL, 32'd3);
    repeat (2) @(negedge clk);
    check("irq_idle", 32'(tx_irq), 1);
    d = 8'($urandom);
    wr(REG_DATA, {24'h0, d});
    e = cyc; s = e + 1;
    wait_until(s + 12);
    wr(REG_BAUDDIV, 32'd7);
    w = cyc;
    chg = (w - s) / 4 + 1;
    len = 4 * chg + 8 * (10 - chg);
    wait_until(s + len + 4);
    check("baudchg_frame", frame_errs(s, d, 4, chg, 8), 0);
    cnt = 0;
    for (int c = s; c < s + len; c++) if (irq_hist[c] !== 1'b0) cnt++;
    check("irq_low_busy", cnt, 0);
    rise = -1;
    for (int c = s + len; c <= s + len + 4; c++)
      if (rise < 0 && irq_hist[c] === 1'b1) rise = c;
    check("irq_rise", 32'((rise >= s + len) && (rise <= s + len + 2)), 1);
    rd(REG_BAUDDIV, r); check("baud_readback", r, 7);

    // Asynchronous reset during the data bits.
    d = 8'($urandom) & 8'hF0;
    nb = 8'($urandom);
    wr(REG_DATA, {24'h0, d});
    e = cyc; s = e + 1;
    wr(REG_DATA, {24'h0, nb});
    wait_until(s + 19);
    check("pre_rst_txd", 32'(txd), 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_txd", 32'(txd), 1);
    check("rst_async_hrdata", hrdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(REG_STATUS, r);  check("status_after_rst", r, exp_status(0, 0, 0));
    rd(REG_BAUDDIV, r); check("baud_after_rst", r, 433);
    rd(REG_CTRL, r);    check("ctrl_after_rst", r, 1);
    e = cyc;
    wait_until(e + 20);
    cnt = 0;
    for (int c = e; c < e + 18; c++) if (txd_hist[c] !== 1'b1) cnt++;
    check("fifo_discarded", cnt, 0);
    check("irq_after_rst", 32'(tx_irq), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
